add_sched: RTL and testbench

Round-robin scheduler that shares one add unit among NUM_REQ requesters.
- Accepts one operand pair at a time from the winning requester and issues it to the add unit.
- Waits for the add unit's held response, forwards it to a single response consumer, then releases the unit with grant.
- Sits between the request sources and the add unit; it is the only block that drives the add unit's add_req and grant.

---
 rtl/add_sched_pkg.sv | 21 ++
 rtl/add_sched_rr_arb.sv | 37 +++
 rtl/add_sched.sv | 151 +++++++++++++++
 tb/tb_add_sched.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sched_pkg.sv
// Shared types for the add-unit round-robin scheduler.
package add_sched_pkg;

  localparam int ADD_ID_W   = 3;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RSP,
    DRAIN
  } sched_state_e;

  typedef struct packed {
    logic [ADD_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data1;
    logic [DEF_DATA_W-1:0] data2;
  } cap_t;

endpackage

// File: rtl/add_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr.
module rr_arb
  import add_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [ADD_ID_W-1:0] ptr,
  input  logic                en,
  output logic [N-1:0]        gnt,
  output logic [ADD_ID_W-1:0] idx,
  output logic                any
);

  logic [N-1:0]      rot;
  logic [ADD_ID_W:0] s;

  // rot[o] is the request sitting o slots past the pointer
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    idx = '0;
    s   = '0;
    for (int o = 0; o < N; o++) begin
      if (en && !any && rot[o]) begin
        any = 1'b1;
        s   = {1'b0, ptr} + (ADD_ID_W+1)'(o);
        if (s >= (ADD_ID_W+1)'(N))
          s = s - (ADD_ID_W+1)'(N);
        idx = s[ADD_ID_W-1:0];
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/add_sched.sv
// Shares one add unit among NUM_REQ requesters, one op in flight,
// with response forwarding, timeout flush and id checking.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data1,
  input  logic [NUM_REQ*DATA_W-1:0] req_data2,
  output logic                      rsp_valid,
  output logic [ADD_ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready,
  output logic                      add_req,
  output logic [ADD_ID_W-1:0]       add_req_id,
  output logic [DATA_W-1:0]         add_data1,
  output logic [DATA_W-1:0]         add_data2,
  input  logic                      add_rsp,
  input  logic [ADD_ID_W-1:0]       add_rsp_id,
  input  logic [DATA_W-1:0]         add_rsp_data,
  input  logic                      add_free,
  output logic                      grant,
  input  logic                      clr_err,
  output logic                      err_timeout,
  output logic                      err_id,
  output logic                      busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_e state, nxt;
  cap_t cap;

  logic [ADD_ID_W-1:0] rr_ptr;
  logic [ADD_ID_W-1:0] win_idx;
  logic [NUM_REQ-1:0]  win_gnt;
  logic                win_any;
  logic                arb_en;
  logic [DATA_W-1:0]   win_d1;
  logic [DATA_W-1:0]   win_d2;
  logic [TW-1:0]       timer;
  logic                tmo;
  logic                id_bad;

  // rst gate keeps req_ready low while reset is held
  assign arb_en = (state == IDLE) && add_free && !rst;

  rr_arb #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    win_d1 = '0;
    win_d2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) begin
        win_d1 = req_data1[i*DATA_W +: DATA_W];
        win_d2 = req_data2[i*DATA_W +: DATA_W];
      end
    end
  end

  assign tmo = (state == WAIT) && !add_rsp
             && (timer == TW'(TIMEOUT - 1));
  assign id_bad = (state == WAIT) && add_rsp
                && (add_rsp_id != cap.id);

  always_comb begin
    nxt       = state;
    req_ready = win_gnt;
    add_req   = 1'b0;
    rsp_valid = 1'b0;
    grant     = 1'b0;
    unique case (state)
      IDLE:  if (win_any) nxt = ISSUE;
      ISSUE: begin
        add_req = 1'b1;
        nxt     = WAIT;
      end
      WAIT: begin
        if (add_rsp) begin
          nxt = RSP;
        end else if (tmo) begin
          grant = 1'b1;
          nxt   = DRAIN;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          grant = 1'b1;
          nxt   = DRAIN;
        end
      end
      DRAIN: if (add_free) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cap         <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      err_id      <= 1'b0;
    end else begin
      state <= nxt;
      if (win_any) begin
        cap.id    <= win_idx;
        cap.data1 <= DEF_DATA_W'(win_d1);
        cap.data2 <= DEF_DATA_W'(win_d2);
        rr_ptr    <= (win_idx == ADD_ID_W'(NUM_REQ - 1))
                   ? '0 : win_idx + 1'b1;
      end
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT)
        timer <= timer + 1'b1;
      // a set event beats a simultaneous clear
      if (tmo)
        err_timeout <= 1'b1;
      else if (clr_err)
        err_timeout <= 1'b0;
      if (id_bad)
        err_id <= 1'b1;
      else if (clr_err)
        err_id <= 1'b0;
    end
  end

  assign rsp_id     = cap.id;
  assign rsp_data   = add_rsp_data;
  assign add_req_id = cap.id;
  assign add_data1  = DATA_W'(cap.data1);
  assign add_data2  = DATA_W'(cap.data2);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched with a behavioural 3-cycle add unit.
module tb_add_sched;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data1;
  logic [N*W-1:0] req_data2;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;
  logic           add_req;
  logic [2:0]     add_req_id;
  logic [W-1:0]   add_data1;
  logic [W-1:0]   add_data2;
  logic           add_rsp;
  logic [2:0]     add_rsp_id;
  logic [W-1:0]   add_rsp_data;
  logic           add_free;
  logic           grant;
  logic           clr_err;
  logic           err_timeout;
  logic           err_id;
  logic           busy;

  int   vecs = 0;
  int   errs = 0;
  int   gcnt = 0;
  logic mute = 1'b0;
  logic bad_id = 1'b0;

  logic       s_busy;
  logic [1:0] s_cnt;
  logic [2:0] s_id;

  always #5 clk = ~clk;

  add_sched #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data1    (req_data1),
    .req_data2    (req_data2),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .add_req      (add_req),
    .add_req_id   (add_req_id),
    .add_data1    (add_data1),
    .add_data2    (add_data2),
    .add_rsp      (add_rsp),
    .add_rsp_id   (add_rsp_id),
    .add_rsp_data (add_rsp_data),
    .add_free     (add_free),
    .grant        (grant),
    .clr_err      (clr_err),
    .err_timeout  (err_timeout),
    .err_id       (err_id),
    .busy         (busy)
  );

  // add unit model: add_rsp rises 3 cycles after add_req, held to grant
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_busy       <= 1'b0;
      s_cnt        <= '0;
      s_id         <= '0;
      add_rsp      <= 1'b0;
      add_rsp_data <= '0;
    end else if (add_req) begin
      s_busy       <= 1'b1;
      s_cnt        <= 2'd1;
      s_id         <= add_req_id;
      add_rsp_data <= add_data1 + add_data2;
    end else if (grant) begin
      s_busy  <= 1'b0;
      s_cnt   <= '0;
      add_rsp <= 1'b0;
    end else if (s_busy && !add_rsp) begin
      if (s_cnt == 2'd2) add_rsp <= !mute;
      else s_cnt <= s_cnt + 2'd1;
    end
  end

  assign add_rsp_id = bad_id ? 3'd5 : s_id;
  assign add_free   = !s_busy;

  always @(negedge clk) if (grant) gcnt++;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input int r,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output logic [2:0] id,
                        output logic [W-1:0] d,
                        output int cyc);
    int n;
    req_valid[r] = 1'b1;
    req_data1[r*W +: W] = a;
    req_data2[r*W +: W] = b;
    #1;
    n = 0;
    while (!req_ready[r] && n < 30) begin
      tick(); #1; n++;
    end
    tick();
    req_valid[r] = 1'b0;
    #1;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      tick(); #1; cyc++;
    end
    id = rsp_id;
    d  = rsp_data;
    if (!rsp_valid) cyc = -1;
  endtask

  task automatic test_reset();
    req_valid = 4'b0100;
    req_data1 = '0;
    req_data2 = '0;
    rsp_ready = 1'b1;
    clr_err   = 1'b0;
    tick(); tick(); #1;
    vecs++;
    if (req_ready !== 4'b0000) begin
      errs++;
      $display("FAIL rst_req_ready got %b want 0000", req_ready);
    end
    vecs++;
    if (add_req !== 1'b0 || grant !== 1'b0) begin
      errs++;
      $display("FAIL rst_add got req=%b grant=%b want 0 0",
               add_req, grant);
    end
    vecs++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_rsp got valid=%b busy=%b want 0 0",
               rsp_valid, busy);
    end
    vecs++;
    if (err_timeout !== 1'b0 || err_id !== 1'b0) begin
      errs++;
      $display("FAIL rst_err got to=%b id=%b want 0 0",
               err_timeout, err_id);
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    int g0;
    g0 = gcnt;
    req_valid[2] = 1'b1;
    req_data1[2*W +: W] = 64'd5;
    req_data2[2*W +: W] = 64'd7;
    #1;
    n = 0;
    while (!req_ready[2] && n < 20) begin
      tick(); #1; n++;
    end
    vecs++;
    if (req_ready !== 4'b0100) begin
      errs++;
      $display("FAIL single_ready got %b want 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    #1;
    vecs++;
    if (add_req !== 1'b1 || add_req_id !== 3'd2
        || add_data1 !== 64'd5 || add_data2 !== 64'd7) begin
      errs++;
      $display("FAIL single_issue got req=%b id=%0d a=%0d b=%0d want 1 2 5 7",
               add_req, add_req_id, add_data1, add_data2);
    end
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick(); #1; n++;
    end
    vecs++;
    if (n !== 4 || rsp_id !== 3'd2 || rsp_data !== 64'd12) begin
      errs++;
      $display("FAIL single_rsp got lat=%0d id=%0d data=%0d want 4 2 12",
               n, rsp_id, rsp_data);
    end
    vecs++;
    if (grant !== 1'b1) begin
      errs++;
      $display("FAIL single_grant got %b want 1", grant);
    end
    tick(); #1;
    n = 0;
    while (busy && n < 10) begin
      tick(); #1; n++;
    end
    vecs++;
    if (busy !== 1'b0 || add_free !== 1'b1 || gcnt - g0 !== 1) begin
      errs++;
      $display("FAIL single_done got busy=%b free=%b grants=%0d want 0 1 1",
               busy, add_free, gcnt - g0);
    end
  endtask

  task automatic test_fairness();
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int exp_d[5]  = '{11, 12, 13, 14, 11};
    int ids[5]    = '{-1, -1, -1, -1, -1};
    logic [W-1:0] dat[5];
    int at[5]     = '{0, 0, 0, 0, 0};
    int k, n, viol;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_data1[i*W +: W] = W'(i + 1);
      req_data2[i*W +: W] = 64'd10;
    end
    req_valid = 4'b1111;
    k = 0; n = 0; viol = 0;
    #1;
    while (k < 5 && n < 80) begin
      if ($countones(req_ready) > 1 || (req_ready != 0 && busy))
        viol++;
      if (rsp_valid) begin
        ids[k] = int'(rsp_id);
        dat[k] = rsp_data;
        at[k]  = n;
        k++;
      end
      tick(); #1; n++;
    end
    req_valid = '0;
    vecs++;
    if (k !== 5) begin
      errs++;
      $display("FAIL fair_count got %0d want 5", k);
    end
    for (int j = 0; j < 5; j++) begin
      vecs++;
      if (ids[j] !== exp_id[j] || dat[j] !== W'(exp_d[j])) begin
        errs++;
        $display("FAIL fair_rsp%0d got id=%0d data=%0d want %0d %0d",
                 j, ids[j], dat[j], exp_id[j], exp_d[j]);
      end
    end
    vecs++;
    if (at[4] - at[0] !== 28) begin
      errs++;
      $display("FAIL fair_rate got %0d cycles want 28", at[4] - at[0]);
    end
    vecs++;
    if (viol !== 0) begin
      errs++;
      $display("FAIL fair_onehot got %0d bad cycles want 0", viol);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [2:0]   id;
    logic [W-1:0] d;
    int cyc, bad, g0;
    rsp_ready = 1'b0;
    run_op(1, 64'd100, 64'd23, id, d, cyc);
    vecs++;
    if (cyc !== 4 || id !== 3'd1 || d !== 64'd123) begin
      errs++;
      $display("FAIL bp_rsp got lat=%0d id=%0d data=%0d want 4 1 123",
               cyc, id, d);
    end
    req_valid[3] = 1'b1;
    req_data1[3*W +: W] = 64'd1;
    req_data2[3*W +: W] = 64'd1;
    g0 = gcnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (!rsp_valid || rsp_data !== 64'd123 || grant
          || req_ready != 0)
        bad++;
    end
    vecs++;
    if (bad !== 0 || gcnt !== g0) begin
      errs++;
      $display("FAIL bp_hold got bad=%0d grants=%0d want 0 0",
               bad, gcnt - g0);
    end
    rsp_ready = 1'b1;
    #1;
    vecs++;
    if (grant !== 1'b1) begin
      errs++;
      $display("FAIL bp_release got grant=%b want 1", grant);
    end
    tick();
    req_valid[3] = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0]   id;
    logic [W-1:0] d;
    int cyc;
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, id, d, cyc);
    vecs++;
    if (cyc !== 4 || id !== 3'd0 || d !== 64'd0
        || err_timeout !== 1'b0 || err_id !== 1'b0) begin
      errs++;
      $display("FAIL wrap got lat=%0d id=%0d data=%h to=%b eid=%b want 4 0 0 0 0",
               cyc, id, d, err_timeout, err_id);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [2:0]   id;
    logic [W-1:0] d;
    int n, cyc, g0;
    logic seen;
    mute = 1'b1;
    req_valid[3] = 1'b1;
    req_data1[3*W +: W] = 64'd1;
    req_data2[3*W +: W] = 64'd2;
    #1;
    n = 0;
    while (!req_ready[3] && n < 30) begin
      tick(); #1; n++;
    end
    tick();
    req_valid[3] = 1'b0;
    g0 = gcnt;
    seen = 1'b0;
    #1;
    n = 0;
    while (!grant && n < 40) begin
      tick(); #1; n++;
      if (rsp_valid) seen = 1'b1;
    end
    vecs++;
    if (n !== 16 || seen !== 1'b0) begin
      errs++;
      $display("FAIL tmo_grant got cycles=%0d rsp_seen=%b want 16 0",
               n, seen);
    end
    tick(); #1;
    vecs++;
    if (err_timeout !== 1'b1 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL tmo_flag got to=%b rsp=%b want 1 0",
               err_timeout, rsp_valid);
    end
    n = 0;
    while (busy && n < 10) begin
      tick(); #1; n++;
    end
    vecs++;
    if (busy !== 1'b0 || gcnt - g0 !== 1) begin
      errs++;
      $display("FAIL tmo_flush got busy=%b grants=%0d want 0 1",
               busy, gcnt - g0);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    vecs++;
    if (err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL tmo_clear got %b want 0", err_timeout);
    end
    mute = 1'b0;
    run_op(1, 64'd20, 64'd22, id, d, cyc);
    vecs++;
    if (cyc !== 4 || id !== 3'd1 || d !== 64'd42
        || err_timeout !== 1'b0) begin
      errs++;
      $display("FAIL tmo_next got lat=%0d id=%0d data=%0d to=%b want 4 1 42 0",
               cyc, id, d, err_timeout);
    end
    tick();
  endtask

  task automatic test_id_rst();
    logic [2:0]   id;
    logic [W-1:0] d;
    int n, cyc, g0;
    bad_id = 1'b1;
    run_op(1, 64'd3, 64'd4, id, d, cyc);
    vecs++;
    if (cyc !== 4 || id !== 3'd1 || d !== 64'd7 || err_id !== 1'b1) begin
      errs++;
      $display("FAIL idm_rsp got lat=%0d id=%0d data=%0d eid=%b want 4 1 7 1",
               cyc, id, d, err_id);
    end
    tick();
    bad_id = 1'b0;
    tick(); tick();
    g0 = gcnt;
    req_valid[0] = 1'b1;
    req_data1[0 +: W] = 64'd9;
    req_data2[0 +: W] = 64'd8;
    #1;
    n = 0;
    while (!req_ready[0] && n < 30) begin
      tick(); #1; n++;
    end
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    vecs++;
    if (add_req !== 1'b0 || grant !== 1'b0 || req_ready !== 4'b0000
        || rsp_valid !== 1'b0 || busy !== 1'b0 || err_id !== 1'b0) begin
      errs++;
      $display("FAIL midrst got req=%b gnt=%b rdy=%b rsp=%b busy=%b eid=%b want all 0",
               add_req, grant, req_ready, rsp_valid, busy, err_id);
    end
    tick();
    rst = 1'b0;
    vecs++;
    if (gcnt !== g0) begin
      errs++;
      $display("FAIL midrst_grant got %0d grants want 0", gcnt - g0);
    end
    run_op(0, 64'd9, 64'd8, id, d, cyc);
    vecs++;
    if (cyc !== 4 || id !== 3'd0 || d !== 64'd17) begin
      errs++;
      $display("FAIL midrst_next got lat=%0d id=%0d data=%0d want 4 0 17",
               cyc, id, d);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_id_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
